// File: rtl/atp_bill_server.sv
// atp_bill_server: billing-host responder that answers kiosk LOOKUP/PAY requests against a per-consumer dues table.
// Define ATP_RESP_TIMEOUT_EN to drop responses the kiosk has not accepted within TIMEOUT_CYCLES.
module atp_bill_server #(
    parameter int ID_W           = 4,
    parameter int AMT_W          = 16,
    parameter int PROC_CYCLES    = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tbl_wr_en,
    input  logic [ID_W-1:0]  tbl_wr_id,
    input  logic [AMT_W-1:0] tbl_wr_amt,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [ID_W-1:0]  req_id,
    input  logic [AMT_W-1:0] req_amt,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [2:0]       resp_status,
    output logic [AMT_W-1:0] resp_amt,
    output logic [15:0]      txn_count,
    output logic             resp_timeout
);

    localparam int DEPTH = 2 ** ID_W;
    localparam int CNT_W = $clog2(PROC_CYCLES + 1);

    localparam logic [1:0] OP_LOOKUP = 2'd0;
    localparam logic [1:0] OP_PAY    = 2'd1;

    localparam logic [2:0] ST_OK        = 3'd0;
    localparam logic [2:0] ST_NO_DUE    = 3'd1;
    localparam logic [2:0] ST_UNDERPAID = 3'd2;
    localparam logic [2:0] ST_BAD_OP    = 3'd3;

    if (PROC_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("atp_bill_server: PROC_CYCLES and TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        PROCESS,
        RESPOND
    } state_t;

    state_t           state_q;
    logic [AMT_W-1:0] due_q [DEPTH];
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       op_q;
    logic [ID_W-1:0]  id_q;
    logic [AMT_W-1:0] paid_q;
    logic             req_ready_q;
    logic             resp_valid_q;
    logic [2:0]       resp_status_q;
    logic [AMT_W-1:0] resp_amt_q;
    logic [15:0]      txn_count_q;

    logic [AMT_W-1:0] due_cur;
    logic [2:0]       status_d;
    logic [AMT_W-1:0] amt_d;
    logic             handshake;
    logic             commit;
    logic             drop;

    assign due_cur = due_q[id_q];

    // Operand order in each subtraction is chosen so the result never wraps.
    always_comb begin
        status_d = ST_BAD_OP;
        amt_d    = '0;
        case (op_q)
            OP_LOOKUP: begin
                if (due_cur != '0) begin
                    status_d = ST_OK;
                    amt_d    = due_cur;
                end else begin
                    status_d = ST_NO_DUE;
                end
            end
            OP_PAY: begin
                if (due_cur == '0) begin
                    status_d = ST_NO_DUE;
                    amt_d    = paid_q;
                end else if (paid_q >= due_cur) begin
                    status_d = ST_OK;
                    amt_d    = paid_q - due_cur;
                end else begin
                    status_d = ST_UNDERPAID;
                    amt_d    = due_cur - paid_q;
                end
            end
            default: ;
        endcase
    end

    assign handshake = (state_q == RESPOND) && resp_ready;
    assign commit    = handshake && (op_q == OP_PAY) && (resp_status_q == ST_OK);

`ifdef ATP_RESP_TIMEOUT_EN
    localparam int HOLD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [HOLD_W-1:0] hold_q;
    logic              resp_timeout_q;

    // The final allowed hold cycle still accepts a handshake; only a silent kiosk is dropped.
    assign drop = (state_q == RESPOND) && !resp_ready && (hold_q == HOLD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q         <= '0;
            resp_timeout_q <= 1'b0;
        end else begin
            resp_timeout_q <= drop;
            if (state_q == RESPOND && !drop) begin
                hold_q <= hold_q + 1'b1;
            end else begin
                hold_q <= '0;
            end
        end
    end

    assign resp_timeout = resp_timeout_q;
`else
    assign drop         = 1'b0;
    assign resp_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            op_q          <= '0;
            id_q          <= '0;
            paid_q        <= '0;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_status_q <= '0;
            resp_amt_q    <= '0;
            txn_count_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                due_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        op_q        <= req_op;
                        id_q        <= req_id;
                        paid_q      <= req_amt;
                        cnt_q       <= CNT_W'(PROC_CYCLES);
                        req_ready_q <= 1'b0;
                        state_q     <= PROCESS;
                    end
                end
                PROCESS: begin
                    if (cnt_q == '0) begin
                        resp_status_q <= status_d;
                        resp_amt_q    <= amt_d;
                        resp_valid_q  <= 1'b1;
                        state_q       <= RESPOND;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESPOND: begin
                    if (handshake || drop) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (commit) begin
                due_q[id_q] <= '0;
                if (txn_count_q != 16'hFFFF) begin
                    txn_count_q <= txn_count_q + 16'd1;
                end
            end
            // Placed after the commit so a same-cycle host write to the same id wins.
            if (tbl_wr_en) begin
                due_q[tbl_wr_id] <= tbl_wr_amt;
            end
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_status = resp_status_q;
    assign resp_amt    = resp_amt_q;
    assign txn_count   = txn_count_q;

endmodule

// File: doc/atp_bill_server.md
Name: atp_bill_server

Overview:
- Billing-host responder serving the ATP kiosk controller. It holds per-consumer dues and answers kiosk requests over a valid/ready request/response pair.
- Lookup returns the amount due. Pay checks the inserted amount against the due amount, returns change or shortfall, and clears the due on commit.
- The kiosk FSM (voucher scan → display → insertion → validation) is the initiator. This block is the validating end.

Parameters:
- ID_W, 4, consumer-id width; table holds 2**ID_W entries.
- AMT_W, 16, amount width in paise, unsigned.
- PROC_CYCLES, 3, processing delay in cycles between request accept and response; legal range is 1 or more.
- TIMEOUT_CYCLES, 255, response-hold limit in cycles; used only with ATP_RESP_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- tbl_wr_en  in  1  write a due amount into the table.
- tbl_wr_id  in  ID_W  table index to write.
- tbl_wr_amt  in  AMT_W  due amount to write.
- req_valid  in  1  kiosk request valid.
- req_ready  out  1  server can accept a request.
- req_op  in  2  request operation: 0=LOOKUP, 1=PAY, 2 and 3 reserved.
- req_id  in  ID_W  consumer id.
- req_amt  in  AMT_W  paid amount (PAY only).
- resp_valid  out  1  response valid.
- resp_ready  in  1  kiosk accepts the response.
- resp_status  out  3  0=OK, 1=NO_DUE, 2=UNDERPAID, 3=BAD_OP.
- resp_amt  out  AMT_W  due amount, change, shortfall, or refund (see Behaviour).
- txn_count  out  16  number of committed payments.
- resp_timeout  out  1  one-cycle pulse when a response is dropped; tied to 0 without the macro.

Behaviour:
- Reset:
  - State is IDLE.
  - req_ready=1, resp_valid=0, resp_status=0, resp_amt=0, txn_count=0, resp_timeout=0.
  - All table entries are 0; processing counter is 0.
  - Reset mid-transaction aborts the transaction with no table or count update.
- FSM:
  - IDLE:
    - req_ready=1.
    - On req_valid & req_ready, latch op, id and amt, load the counter with PROC_CYCLES, and go to PROCESS.
  - PROCESS:
    - req_ready=0; the counter decrements each cycle.
    - When it reaches 0, register the response fields and go to RESPOND.
    - The due value is sampled from the table in the last PROCESS cycle.
  - RESPOND:
    - resp_valid=1; resp_status and resp_amt are held stable until resp_valid & resp_ready.
    - On the handshake cycle, commit (see below) and return to IDLE.
    - req_ready returns to 1 on the next cycle, so back-to-back accept occurs at the earliest one cycle after the response handshake.
- Latency: resp_valid first rises exactly PROC_CYCLES+1 clock edges after the accept edge.
- Response rules (due = table[id]):
  - LOOKUP, due>0: OK, amt=due.
  - LOOKUP, due=0: NO_DUE, amt=0.
  - PAY, due=0: NO_DUE, amt=paid (full refund).
  - PAY, paid>=due: OK, amt=paid-due (change).
  - PAY, paid<due: UNDERPAID, amt=due-paid (shortfall); no commit, cash is returned.
  - op 2 or 3: BAD_OP, amt=0.
  - All subtraction is unsigned AMT_W-bit and operand order guarantees no wrap.
- Commit:
  - Only a PAY with status OK commits, and only on the response handshake.
  - Commit sets table[id] to 0 and increments txn_count, saturating at 16'hFFFF.
- Table writes:
  - Accepted in any state.
  - If a write hits the same id as a commit in the same cycle, the table write wins; txn_count still increments.
  - A write landing during PROCESS before the last PROCESS cycle is visible to the response.

Optional Feature:
- Macro ATP_RESP_TIMEOUT_EN.
- Defined:
  - A hold counter starts when RESPOND is entered.
  - If resp_ready has not been seen after TIMEOUT_CYCLES cycles with resp_valid high, drop the response: resp_valid=0, no commit, resp_timeout=1 for one cycle, return to IDLE.
  - A handshake in the final allowed cycle still commits.
- Undefined: RESPOND holds indefinitely and resp_timeout is constant 0.

Test Plan:
- Reset, write id 3 = 1500, LOOKUP id 3 → resp_valid exactly 4 edges after accept; OK, amt=1500; req_ready=0 during PROCESS.
- PAY id 3 with 2000, resp_ready held 2 cycles late → status/amt stable until handshake; OK, amt=500; table[3]=0; txn_count=1; follow-up LOOKUP id 3 → NO_DUE, 0.
- Write id 5 = 800, PAY 600 → UNDERPAID, amt=200; table[5] stays 800; txn_count unchanged. PAY id 9 (due 0) with 300 → NO_DUE, amt=300.
- req_op=2 → BAD_OP, amt=0. Commit cycle on id 7 coincides with tbl_wr id 7 = 999 → table[7]=999 and txn_count increments. Preload txn_count to 16'hFFFF with a further OK pay → txn_count stays 16'hFFFF.
- rst asserted in PROCESS and separately in RESPOND → next cycle state IDLE, resp_valid=0, table cleared, txn_count=0.
- With ATP_RESP_TIMEOUT_EN and TIMEOUT_CYCLES=4, PAY OK with resp_ready never asserted → resp_timeout pulses once, table and count unchanged, req_ready=1 next cycle. Handshake on the 4th cycle → commits normally.
